// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive deframer: data width, bit-counter
//   width and the deframer FSM state encoding.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if
//   Bundles the serial line and the byte-side results of the deframer.
//   Ports (signals):
//     rx_in       serial line, idles high
//     rx_dataout  received byte, bit 0 = first data bit on the line
//     rx_valid    one-cycle pulse for a complete, error-free frame
//     pb_error    parity error flag for the last frame
//     sb_error    stop-bit (framing) error flag for the last frame
//   Modports:
//     master  line driver / byte consumer side
//     slave   the deframer itself
interface uart_rx_deframer_if;
  import uart_rx_pkg::*;

  logic                      rx_in;
  logic [UART_DATA_BITS-1:0] rx_dataout;
  logic                      rx_valid;
  logic                      pb_error;
  logic                      sb_error;

  modport master (
    output rx_in,
    input  rx_dataout, rx_valid, pb_error, sb_error
  );

  modport slave (
    input  rx_in,
    output rx_dataout, rx_valid, pb_error, sb_error
  );

endinterface

// File: rtl/uart_rx_shift.sv
// uart_rx_shift
//   Serial-in / parallel-out register. Each enabled cycle the new bit enters
//   at the MSB and the register shifts right, so after W shifts the first bit
//   received sits in bit 0 (LSB-first line order).
//   Ports:
//     clk       bit clock
//     rst       asynchronous active-low reset (clears the register)
//     shift_en  shift one bit in this cycle
//     din       serial input bit
//     dout      parallel contents
module uart_rx_shift
  import uart_rx_pkg::*;
#(
  parameter int W = UART_DATA_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          dout <= '0;
    else if (shift_en) dout <= {din, dout[W-1:1]};
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Receive-side UART deframer, one line bit per clk (no oversampling).
//   Frame: start(0), 8 data bits LSB-first, parity, stop(1).
//   Parameters:
//     PARITY_ODD  0 = even parity, 1 = odd parity
//   Ports:
//     clk   bit clock, line sampled on the rising edge
//     rst   asynchronous active-low reset; aborts any frame in progress
//     bus   uart_rx_deframer_if.slave (rx_in, rx_dataout, rx_valid,
//           pb_error, sb_error); all outputs are registered
//   Configuration macro:
//     UART_RX_STOP_CHECK_EN  when defined, the stop bit is checked, sb_error
//                            is live and the break guard (armed) is present;
//                            when undefined, sb_error = 0 and armed = 1.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_deframer_if.slave  bus
);

  localparam logic [UART_CNT_W-1:0] CNT_LAST = UART_CNT_W'(UART_DATA_BITS - 1);

  rx_state_e                 state_q, state_nxt;
  logic [UART_CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      shift_en;
  logic                      valid_q, valid_nxt;
  logic                      pb_q, pb_nxt;
  logic                      sb_q;
  logic                      armed_q;
  logic                      exp_par;

`ifdef UART_RX_STOP_CHECK_EN
  logic                      sb_nxt;
  logic                      armed_nxt;
`else
  assign sb_q    = 1'b0;
  assign armed_q = 1'b1;
`endif

  uart_rx_shift #(.W(UART_DATA_BITS)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (bus.rx_in),
    .dout     (data_q)
  );

  // Parity bit that makes the frame match the selected parity sense.
  assign exp_par = (^data_q) ^ PARITY_ODD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pb_q    <= 1'b0;
`ifdef UART_RX_STOP_CHECK_EN
      sb_q    <= 1'b0;
      armed_q <= 1'b1;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      valid_q <= valid_nxt;
      pb_q    <= pb_nxt;
`ifdef UART_RX_STOP_CHECK_EN
      sb_q    <= sb_nxt;
      armed_q <= armed_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_en  = 1'b0;
    valid_nxt = 1'b0;
    pb_nxt    = pb_q;
`ifdef UART_RX_STOP_CHECK_EN
    sb_nxt    = sb_q;
    armed_nxt = armed_q;
`endif
    case (state_q)
      IDLE: begin
        // A low line is only a start bit once the line has been seen high
        // since the last framing error; a held break cannot retrigger.
        if (!bus.rx_in && armed_q) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          pb_nxt    = 1'b0;
`ifdef UART_RX_STOP_CHECK_EN
          sb_nxt    = 1'b0;
`endif
        end
`ifdef UART_RX_STOP_CHECK_EN
        if (bus.rx_in) armed_nxt = 1'b1;
`endif
      end
      DATA: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_nxt = PARITY;
      end
      PARITY: begin
        // A parity failure drops the frame here; the stop bit then lands in
        // IDLE, where its high level simply re-arms.
        if (bus.rx_in != exp_par) begin
          pb_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        state_nxt = IDLE;
`ifdef UART_RX_STOP_CHECK_EN
        if (bus.rx_in) begin
          valid_nxt = 1'b1;
        end else begin
          sb_nxt    = 1'b1;
          armed_nxt = 1'b0;
        end
`else
        valid_nxt = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rx_dataout = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.pb_error   = pb_q;
  assign bus.sb_error   = sb_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   prev_t = 0;
  int   last_t = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_q[$];

`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHK = 1'b1;
`else
  localparam bit STOP_CHK = 1'b0;
`endif

  uart_rx_deframer_if bus0 ();
  uart_rx_deframer_if bus1 ();

  uart_rx_deframer #(.PARITY_ODD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx_deframer #(.PARITY_ODD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse on dut0 must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst && bus0.rx_valid) begin
      prev_t = last_t;
      last_t = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("sb_byte", {24'd0, bus0.rx_dataout}, {24'd0, exp_q.pop_front()});
        chk("sb_flags", {30'd0, bus0.pb_error, bus0.sb_error}, 32'd0);
      end
    end
  end

  // Called at a falling edge: present one bit, return at the next falling edge
  // (the bit has been sampled by the rising edge in between).
  task automatic drive(input logic b);
    bus0.rx_in = b;
    @(negedge clk);
  endtask

  task automatic drive1(input logic b);
    bus1.rx_in = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic par_ok;
    logic good;
    par_ok = (par == (^d));
    good   = par_ok && (stp || !STOP_CHK);
    if (good) exp_q.push_back(d);
    drive(1'b0);
    chk("flags_clear_E0", {30'd0, bus0.pb_error, bus0.sb_error}, 32'd0);
    for (int i = 0; i < 8; i++) drive(d[i]);
    chk("data_E8", {24'd0, bus0.rx_dataout}, {24'd0, d});
    last_byte = d;
    drive(par);
    chk("pb_E9", {31'd0, bus0.pb_error}, {31'd0, !par_ok});
    drive(stp);
    chk("valid_E10", {31'd0, bus0.rx_valid}, {31'd0, good});
    chk("sb_E10", {31'd0, bus0.sb_error}, {31'd0, par_ok && !stp && STOP_CHK});
  endtask

  initial begin
    rst = 1'b0;
    bus0.rx_in = 1'b1;
    bus1.rx_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, bus0.rx_dataout}, 32'd0);
    chk("rst_flags", {29'd0, bus0.rx_valid, bus0.pb_error, bus0.sb_error}, 32'd0);
    rst = 1'b1;
    drive(1'b1);
    drive(1'b1);

    // 0xA5, even parity 0, good stop
    send_frame(8'hA5, 1'b0, 1'b1);
    drive(1'b1);
    chk("a5_valid_one_cycle", {31'd0, bus0.rx_valid}, 32'd0);

    // 0x01 with wrong parity: aborted, stop bit lands in IDLE
    send_frame(8'h01, 1'b0, 1'b1);
    drive(1'b1);
    chk("perr_no_valid_E11", {31'd0, bus0.rx_valid}, 32'd0);
    chk("perr_sticky", {31'd0, bus0.pb_error}, 32'd1);
    send_frame(8'h01, 1'b1, 1'b1);
    drive(1'b1);

    // 0x3C with bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    if (STOP_CHK) begin
      for (int i = 0; i < 5; i++) drive(1'b0);
      chk("break_sb_sticky", {31'd0, bus0.sb_error}, 32'd1);
      chk("break_no_frame", {24'd0, bus0.rx_dataout}, 32'h3C);
      drive(1'b1);
      send_frame(8'h5A, 1'b0, 1'b1);
    end
    drive(1'b1);

    // Reset after E4 of 0xFF
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    chk("ff_data_E4", {24'd0, bus0.rx_dataout}, {24'd0, 4'hF, last_byte[7:4]});
    rst = 1'b0;
    #1;
    chk("midrst_data", {24'd0, bus0.rx_dataout}, 32'd0);
    chk("midrst_flags", {29'd0, bus0.rx_valid, bus0.pb_error, bus0.sb_error}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_byte = 8'h00;
    drive(1'b1);
    chk("post_rst_idle", {24'd0, bus0.rx_dataout}, 32'd0);
    send_frame(8'h55, 1'b0, 1'b1);
    drive(1'b1);

    // Back-to-back 0x12, 0x34
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    drive(1'b1);
    chk("b2b_gap", last_t - prev_t, 32'd11);

    // Odd-parity instance: 0x00 with parity 1 is good, with parity 0 is not
    drive1(1'b0);
    for (int i = 0; i < 8; i++) drive1(1'b0);
    drive1(1'b1);
    chk("odd_pb_ok", {31'd0, bus1.pb_error}, 32'd0);
    drive1(1'b1);
    chk("odd_valid", {31'd0, bus1.rx_valid}, 32'd1);
    chk("odd_data", {24'd0, bus1.rx_dataout}, 32'd0);
    drive1(1'b0);
    for (int i = 0; i < 8; i++) drive1(1'b0);
    drive1(1'b0);
    chk("odd_pb_bad", {31'd0, bus1.pb_error}, 32'd1);
    drive1(1'b1);
    chk("odd_bad_no_valid", {31'd0, bus1.rx_valid}, 32'd0);
    drive1(1'b1);

    drive(1'b1);
    drive(1'b1);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
